// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit:
// state enum, opcode constants and the ALU / mux select encodings.
package multicycle_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    TRAP      = 4'd12
  } state_t;

  // Opcodes, IR[31:26]
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  // alu_op encodings
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // alu_src_b encodings
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // pc_source encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// State-to-control-signal decode for the multi-cycle controller.
// Purely combinational. Inputs: current state, mem_ready (only used by
// the FETCH Mealy terms ir_write / pc_write). Outputs: all datapath
// control strobes and selects, plus the illegal-opcode trap flag.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal
);

  // Every output defaults low; each state raises only what it needs
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    illegal       = 1'b0;

    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR and PC only capture on the cycle memory actually delivers
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
      end
      MEM_ADDR, ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      ADDI_WB: begin
        reg_write = 1'b1;
      end
      TRAP: begin
        illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit. Sequences each instruction through
// fetch/decode/execute/memory/writeback over a shared ALU and one memory
// port, with memory wait states, an illegal-opcode trap and a retired
// instruction counter.
// Ports: clk, rst_n (sync, active low), opcode (IR[31:26], sampled in
// DECODE), mem_ready (memory access completes this cycle); outputs are the
// datapath controls, illegal (trapped) and instr_count (retired count).
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter bit          ENABLE_ADDI = 1'b1,
  parameter bit          ENABLE_JUMP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              retire;

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = R_EXEC;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = ENABLE_JUMP ? JUMP : TRAP;
          OP_ADDI:      state_d = ENABLE_ADDI ? ADDI_EXEC : TRAP;
          default:      state_d = TRAP;
        endcase
      end
      // Only LW and SW reach MEM_ADDR, so anything but LW is a store
      MEM_ADDR:  state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:    if (mem_ready) state_d = MEM_WB;
      MEM_WB:    state_d = FETCH;
      MEM_WR:    if (mem_ready) state_d = FETCH;
      R_EXEC:    state_d = R_WB;
      R_WB:      state_d = FETCH;
      BRANCH:    state_d = FETCH;
      JUMP:      state_d = FETCH;
      ADDI_EXEC: state_d = ADDI_WB;
      ADDI_WB:   state_d = FETCH;
      TRAP:      state_d = TRAP;
      default:   state_d = FETCH;
    endcase
  end

  // An instruction retires on the edge that returns to FETCH
  assign retire = (state_d == FETCH) && (state_q != FETCH);

  // State, latched opcode and retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= opcode;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign instr_count = cnt_q;

  multicycle_ctrl_decode u_decode (
    .state         (state_q),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal       (illegal)
  );

endmodule
